// File: rtl/uart_rx.sv
// UART 8N1 receiver with a 2-FF input synchronizer and mid-bit sampling.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLK_FREQ_KHz  = 50000,
  parameter int unsigned BAUD_RATE_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int unsigned BIT_CLOCKS  = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS;
  localparam int unsigned HALF_CLOCKS = BIT_CLOCKS / 2;
  localparam int unsigned CntW        = (BIT_CLOCKS > 1) ? $clog2(BIT_CLOCKS) : 1;

  localparam logic [CntW-1:0] BitMax  = CntW'(BIT_CLOCKS - 1);
  localparam logic [CntW-1:0] HalfMax = CntW'(HALF_CLOCKS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StWait   = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif

  logic            rx_meta_q, rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;
  logic            busy_q;
  logic            par_bad;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            pe_q, pe_d;
`endif

`ifdef UART_RX_PARITY_EN
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfMax) begin
          cnt_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitMax) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitMax) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitMax) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          pe_d  = par_bad;
`endif
          if (rx_s_q) begin
            if (!par_bad) begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end
            state_d = StIdle;
          end else begin
            fe_d    = 1'b1;
            state_d = StWait;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        // Hold off until the line is released so a break cannot retrigger
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      busy_q    <= (state_d != StIdle);
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit; parity cases run when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];   // bytes expected on data_valid
  logic [7:0] fe_q[$];    // data value expected to be held at each frame_err
`ifdef UART_RX_PARITY_EN
  logic [7:0] pe_q[$];
`endif

  uart_rx #(
    .CLK_FREQ_KHz (1000),
    .BAUD_RATE_BPS(100000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes an output
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (data_valid) begin
        if (exp_q.size() == 0) check("dv_unexpected", 8'd1, 8'd0);
        else check("rx_data", data, exp_q.pop_front());
      end
      if (frame_err) begin
        if (fe_q.size() == 0) check("fe_unexpected", 8'd1, 8'd0);
        else check("fe_data_held", data, fe_q.pop_front());
      end
`ifdef UART_RX_PARITY_EN
      if (parity_err) begin
        if (pe_q.size() == 0) check("pe_unexpected", 8'd1, 8'd0);
        else check("pe_data_held", data, pe_q.pop_front());
      end
`endif
    end
  end

  task automatic send_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start_data(input logic [7:0] b);
    send_bit(1'b0, 10);
    for (int i = 0; i < 8; i++) send_bit(b[i], 10);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_val);
    send_start_data(b);
`ifdef UART_RX_PARITY_EN
    send_bit(^b, 10);
`endif
    send_bit(stop_val, stop_len);
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", data, 8'h00);
    check("reset_dv", {7'd0, data_valid}, 8'd0);
    check("reset_fe", {7'd0, frame_err}, 8'd0);
    check("reset_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean frame
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 10, 1'b1);
    repeat (12) @(negedge clk);
    check("a5_busy_after", {7'd0, busy}, 8'd0);
    check("a5_data", data, 8'hA5);

    // Short glitch: StartBit entered then rejected
    send_bit(1'b0, 3);
    rx = 1'b1;
    @(negedge clk);
    check("glitch_busy_high", {7'd0, busy}, 8'd1);
    repeat (10) @(negedge clk);
    check("glitch_busy_low", {7'd0, busy}, 8'd0);
    check("glitch_data_held", data, 8'hA5);

    // Framing error with a long low stop bit, then recovery
    fe_q.push_back(8'hA5);
    send_start_data(8'h3C);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h3C, 10);
`endif
    send_bit(1'b0, 30);
    check("break_busy_high", {7'd0, busy}, 8'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("break_busy_low", {7'd0, busy}, 8'd0);
    check("break_data_held", data, 8'hA5);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 10, 1'b1);
    repeat (12) @(negedge clk);

    // Back-to-back frames with no idle gap
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 10, 1'b1);
    send_frame(8'hFF, 10, 1'b1);
    repeat (12) @(negedge clk);
    check("b2b_last_data", data, 8'hFF);

    // Reset during data bit 3
    send_bit(1'b0, 10);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 10);
    send_bit(1'b0, 5);
    check("midframe_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check("midrst_data", data, 8'h00);
    check("midrst_dv", {7'd0, data_valid}, 8'd0);
    check("midrst_fe", {7'd0, frame_err}, 8'd0);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 10, 1'b1);
    repeat (12) @(negedge clk);
    check("after_rst_data", data, 8'h5A);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_start_data(8'h07);
    send_bit(1'b1, 10);
    send_bit(1'b1, 10);
    repeat (12) @(negedge clk);
    pe_q.push_back(8'h07);
    send_start_data(8'h07);
    send_bit(1'b0, 10);
    send_bit(1'b1, 10);
    repeat (12) @(negedge clk);
    check("pe_busy_low", {7'd0, busy}, 8'd0);
`endif

    repeat (20) @(negedge clk);
    check("dv_missing", 8'(exp_q.size()), 8'd0);
    check("fe_missing", 8'(fe_q.size()), 8'd0);
`ifdef UART_RX_PARITY_EN
    check("pe_missing", 8'(pe_q.size()), 8'd0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
